// File: rtl/cache_pkg.sv
// Shared definitions for the cache memory arbiter: arbiter state encoding and
// cache block geometry.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WRITE  = 2'b01,
    FILL_I = 2'b10,
    FILL_D = 2'b11
  } arb_state_e;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_BYTES     = 16;
  localparam logic [15:0] BLOCK_OFF_MASK = 16'(BLOCK_BYTES - 1);

endpackage

// File: rtl/cache_fill_counter.sv
// Block-fill bookkeeping: latched block base, issue/receive word counters and
// the read address generator for the current fill.
module cache_fill_counter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_grant,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_issue,
  input  logic              i_recv,
  output logic              o_issue_active,
  output logic [ADDR_W-1:0] o_addr,
  output logic [IDX_W-1:0]  o_recv_idx,
  output logic              o_recv_last
);

  // One bit wider than the word index so a full block count is representable.
  localparam int CNT_W = IDX_W + 1;

  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_recv_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else if (i_grant) begin
      r_base      <= i_base;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      if (i_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
      if (i_recv)  r_recv_cnt  <= r_recv_cnt + 1'b1;
    end
  end

  assign o_issue_active = (r_issue_cnt < CNT_W'(WORDS_PER_BLOCK));
  assign o_addr         = r_base + (ADDR_W'(r_issue_cnt) << 1);
  assign o_recv_idx     = r_recv_cnt[IDX_W-1:0];
  assign o_recv_last    = (r_recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one pipelined multicycle memory between I-fills, D-fills and D
// write-through stores. Optional fill counters under CACHE_ARB_PERF_EN.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [15:0]       d_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       fill_data,
  output logic [IDX_W-1:0]  fill_word,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
`ifdef CACHE_ARB_PERF_EN
  ,
  output logic [15:0]       i_fill_cnt,
  output logic [15:0]       d_fill_cnt
`endif
);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  // The fill sequencing relies on in-order responses at least one cycle out.
  if (MEM_LATENCY < 1) begin : g_lat_chk
    $error("cache_mem_arbiter: MEM_LATENCY must be >= 1");
  end

  arb_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;

  logic              w_grant;
  logic [ADDR_W-1:0] w_grant_addr;
  logic              w_fill;
  logic              w_issue_active;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [IDX_W-1:0]  w_recv_idx;
  logic              w_recv_last;

  assign w_fill = (r_state == FILL_I) || (r_state == FILL_D);

  cache_fill_counter #(
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .ADDR_W          (ADDR_W),
    .IDX_W           (IDX_W)
  ) u_cnt (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_grant        (w_grant),
    .i_base         (w_grant_addr & ~OFF_MASK),
    .i_issue        (w_fill && w_issue_active),
    .i_recv         (w_fill && mem_rvalid),
    .o_issue_active (w_issue_active),
    .o_addr         (w_fill_addr),
    .o_recv_idx     (w_recv_idx),
    .o_recv_last    (w_recv_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant && w_next == WRITE) begin
        r_wr_addr <= d_wr_addr;
        r_wr_data <= d_wr_data;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_grant_addr = '0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    d_wr_ack     = 1'b0;
    fill_data    = '0;
    fill_word    = '0;
    i_fill_we    = 1'b0;
    d_fill_we    = 1'b0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // D side first: a D miss already stalls the whole pipeline.
        if (d_wr_req) begin
          w_next = WRITE;  w_grant = 1'b1; w_grant_addr = d_wr_addr;
        end else if (d_miss_req) begin
          w_next = FILL_D; w_grant = 1'b1; w_grant_addr = d_miss_addr;
        end else if (i_miss_req) begin
          w_next = FILL_I; w_grant = 1'b1; w_grant_addr = i_miss_addr;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = r_wr_addr;
        mem_wdata = r_wr_data;
        d_wr_ack  = 1'b1;
        w_next    = IDLE;
      end
      FILL_I, FILL_D: begin
        mem_en   = w_issue_active;
        mem_addr = w_issue_active ? w_fill_addr : '0;
        if (mem_rvalid) begin
          fill_data = mem_rdata;
          fill_word = w_recv_idx;
          if (r_state == FILL_I) begin
            i_fill_we   = 1'b1;
            i_fill_done = w_recv_last;
          end else begin
            d_fill_we   = 1'b1;
            d_fill_done = w_recv_last;
          end
          if (w_recv_last) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

`ifdef CACHE_ARB_PERF_EN
  logic [15:0] r_i_fill_cnt, r_d_fill_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i_fill_cnt <= '0;
      r_d_fill_cnt <= '0;
    end else begin
      if (i_fill_done && r_i_fill_cnt != 16'hFFFF) r_i_fill_cnt <= r_i_fill_cnt + 1'b1;
      if (d_fill_done && r_d_fill_cnt != 16'hFFFF) r_d_fill_cnt <= r_d_fill_cnt + 1'b1;
    end
  end

  assign i_fill_cnt = r_i_fill_cnt;
  assign d_fill_cnt = r_d_fill_cnt;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scoreboard bench for cache_mem_arbiter with a 4-cycle pipelined
// memory model; expected reads/writes/fill words queued at stimulus time.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;
`ifdef CACHE_ARB_PERF_EN
  logic [15:0] i_fill_cnt, d_fill_cnt;
`endif

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .busy(busy)
`ifdef CACHE_ARB_PERF_EN
    , .i_fill_cnt(i_fill_cnt), .d_fill_cnt(d_fill_cnt)
`endif
  );

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hA5C3;
  endfunction

  // Memory model: in-order, 4-cycle read latency, one request per cycle.
  logic [3:0]  pv = '0;
  logic [15:0] pd [4];
  logic        inj = 1'b0;
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pd[0] <= mdata(mem_addr);
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end
  assign mem_rvalid = pv[3] | inj;
  assign mem_rdata  = inj ? 16'hDEAD : pd[3];

  typedef struct { logic is_d; logic [2:0] word; logic [15:0] data; } fill_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  fill_t       fq[$];
  logic [15:0] aq[$];
  wr_t         wq[$];

  int errs = 0, checks = 0, cyc_n = 0;
  bit i_done_seen, d_done_seen, d_w3_seen, gap_arm;
  int d_done_cyc, gap_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    fill_t e;
    wr_t   w;
    if (mem_en && mem_wr) begin
      if (wq.size() == 0) chk("unexp_write", 32'(mem_en), 32'd0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(w.addr));
        chk("wr_data", 32'(mem_wdata), 32'(w.data));
        chk("wr_ack", 32'(d_wr_ack), 32'd1);
      end
    end
    if (mem_en && !mem_wr) begin
      if (aq.size() == 0) chk("unexp_read", 32'(mem_en), 32'd0);
      else chk("rd_addr", 32'(mem_addr), 32'(aq.pop_front()));
      if (gap_arm) begin gap_first = cyc_n; gap_arm = 1'b0; end
    end
    if (i_fill_we || d_fill_we) begin
      if (fq.size() == 0) chk("unexp_fill", 32'({i_fill_we, d_fill_we}), 32'd0);
      else begin
        e = fq.pop_front();
        chk("fill_sel", 32'({i_fill_we, d_fill_we}), e.is_d ? 32'd1 : 32'd2);
        chk("fill_word", 32'(fill_word), 32'(e.word));
        chk("fill_data", 32'(fill_data), 32'(e.data));
        chk("fill_done", 32'({i_fill_done, d_fill_done}),
            (e.word == 3'd7) ? (e.is_d ? 32'd1 : 32'd2) : 32'd0);
        if (i_fill_done) i_done_seen = 1'b1;
        if (d_fill_done) begin d_done_seen = 1'b1; d_done_cyc = cyc_n; gap_arm = 1'b1; end
        if (d_fill_we && fill_word == 3'd3) d_w3_seen = 1'b1;
      end
    end else if (i_fill_done || d_fill_done) begin
      chk("stray_done", 32'({i_fill_done, d_fill_done}), 32'd0);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic push_fill(input logic is_d, input logic [15:0] addr);
    logic [15:0] base, a;
    base = addr & ~16'h000F;
    for (int w = 0; w < 8; w++) begin
      a = base + 16'(2 * w);
      aq.push_back(a);
      fq.push_back('{is_d, 3'(w), mdata(a)});
    end
  endtask

  task automatic run_until_done(input bit want_d);
    int n;
    n = 0;
    if (want_d) d_done_seen = 1'b0; else i_done_seen = 1'b0;
    while (!(want_d ? d_done_seen : i_done_seen) && n < 40) begin cyc(); n++; end
    chk(want_d ? "d_done_timeout" : "i_done_timeout",
        32'(want_d ? d_done_seen : i_done_seen), 32'd1);
  endtask

  initial begin
    int t0, n;
    rst_n = 1'b0; i_miss_req = 0; d_miss_req = 0; d_wr_req = 0;
    i_miss_addr = 0; d_miss_addr = 0; d_wr_addr = 0; d_wr_data = 0;
    gap_arm = 0; d_done_cyc = 0; gap_first = 0;
    @(posedge clk); #1;
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({mem_en, mem_wr, d_wr_ack, i_fill_we, d_fill_we, i_fill_done, d_fill_done}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Single I fill, block base 0x0040, done exactly 12 cycles after grant.
    i_miss_req = 1; i_miss_addr = 16'h0046; push_fill(0, 16'h0046);
    t0 = cyc_n;
    run_until_done(0);
    i_miss_req = 0;
    chk("i_done_cycle", 32'(cyc_n - 1 - t0), 32'd12);
    chk("idle_after_fill", 32'(busy), 32'd0);
    chk("q_empty1", 32'(fq.size() + aq.size()), 32'd0);

    // Simultaneous misses: D first, I granted after one idle cycle.
    i_miss_req = 1; i_miss_addr = 16'h0010;
    d_miss_req = 1; d_miss_addr = 16'h2000;
    push_fill(1, 16'h2000); push_fill(0, 16'h0010);
    run_until_done(1);
    d_miss_req = 0;
    run_until_done(0);
    i_miss_req = 0;
    chk("gap_after_d", 32'(gap_first - d_done_cyc), 32'd2);
    chk("q_empty2", 32'(fq.size() + aq.size()), 32'd0);

    // Store beats a pending I miss; store operands latched at grant.
    d_wr_req = 1; d_wr_addr = 16'h1234; d_wr_data = 16'hBEEF;
    i_miss_req = 1; i_miss_addr = 16'h0300;
    wq.push_back('{16'h1234, 16'hBEEF}); push_fill(0, 16'h0300);
    cyc();
    d_wr_addr = 16'hFFFF; d_wr_data = 16'h0000;
    chk("wr_state_busy", 32'(busy), 32'd1);
    cyc();
    d_wr_req = 0;
    chk("wq_empty", 32'(wq.size()), 32'd0);
    run_until_done(0);
    i_miss_req = 0;
    chk("q_empty3", 32'(fq.size() + aq.size()), 32'd0);

    // Request dropped mid-fill: fill still completes.
    i_miss_req = 1; i_miss_addr = 16'h0500; push_fill(0, 16'h0500);
    cyc(); cyc(); cyc(); cyc();
    i_miss_req = 0;
    run_until_done(0);
    chk("q_empty4", 32'(fq.size() + aq.size()), 32'd0);
`ifdef CACHE_ARB_PERF_EN
    chk("perf_i", 32'(i_fill_cnt), 32'd4);
    chk("perf_d", 32'(d_fill_cnt), 32'd1);
`endif

    // Reset during receive of word 4; late responses must be dropped.
    d_miss_req = 1; d_miss_addr = 16'h0600; push_fill(1, 16'h0600);
    d_w3_seen = 0; n = 0;
    while (!d_w3_seen && n < 40) begin cyc(); n++; end
    chk("w3_timeout", 32'(d_w3_seen), 32'd1);
    rst_n = 0; d_miss_req = 0;
    cyc();
    rst_n = 1;
    fq.delete(); aq.delete();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("late_we", 32'({i_fill_we, d_fill_we}), 32'd0);
      cyc();
    end
    inj = 1; #1;
    chk("stray_rvalid", 32'({i_fill_we, d_fill_we, busy}), 32'd0);
    @(negedge clk); inj = 0; @(posedge clk); #1; cyc_n++;

    d_miss_req = 1; d_miss_addr = 16'h0700; push_fill(1, 16'h0700);
    run_until_done(1);
    d_miss_req = 0;
    cyc();
    chk("q_empty5", 32'(fq.size() + aq.size()), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);
`ifdef CACHE_ARB_PERF_EN
    chk("perf_i_rst", 32'(i_fill_cnt), 32'd0);
    chk("perf_d_rst", 32'(d_fill_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
